pe_weight_loader: RTL and testbench

Weight-bus writer for the processing elements. It accepts a stream of 32-bit packed words, each carrying two 16-bit weights. It unpacks them and drives the `weight_wr_data` / `weight_wr_addr` / `weight_wr_en` write bus into a PE's kernel RAM, bias RAM and coefficient registers. Writes go to consecutive addresses starting at `BASE_ADDR`. It sits between the off-chip/DMA weight stream and one or more PE instances that share the write bus.

---
 rtl/pe_weight_loader_pkg.sv | 13 +
 rtl/pe_weight_loader_if.sv | 25 ++
 rtl/pe_weight_loader.sv | 74 +++++++
 tb/tb_pe_weight_loader.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/pe_weight_loader_pkg.sv
// Shared types and constants for the PE weight-bus loader.
package pe_weight_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd23;
  localparam int unsigned WORD_WIDTH        = 32;

endpackage

// File: rtl/pe_weight_loader_if.sv
// Packed-word stream in, weight write bus out, plus load control/status.
interface pe_weight_loader_if;
  import pe_weight_loader_pkg::*;

  logic                  start;
  logic [WORD_WIDTH-1:0] i_data;
  logic                  i_valid;
  logic                  i_ready;
  logic [15:0]           weight_wr_data;
  logic [31:0]           weight_wr_addr;
  logic                  weight_wr_en;
  logic                  busy;
  logic                  done;

  modport master (
    output start, i_data, i_valid,
    input  i_ready, weight_wr_data, weight_wr_addr, weight_wr_en, busy, done
  );

  modport slave (
    input  start, i_data, i_valid,
    output i_ready, weight_wr_data, weight_wr_addr, weight_wr_en, busy, done
  );

endinterface

// File: rtl/pe_weight_loader.sv
// Unpacks 32-bit words into two 16-bit weights and writes them to
// consecutive weight-bus addresses starting at BASE_ADDR.
module pe_weight_loader
  import pe_weight_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned NUM_WEIGHTS = 226,
  parameter int unsigned CNT_WIDTH   = $clog2(NUM_WEIGHTS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  pe_weight_loader_if.slave bus
);

  state_t               state;
  state_t               state_next;
  logic [CNT_WIDTH-1:0] wr_cnt;
  logic [CNT_WIDTH-1:0] remaining;
  logic [15:0]          hold_data;
  logic                 hold_valid;
  logic                 accept;
  logic                 write;
  logic                 last_write;

  // A held upper half blocks new words, so accept and hold-emit never coincide.
  assign bus.i_ready = (state == LOAD) && !hold_valid && (remaining != '0);
  assign accept      = bus.i_valid && bus.i_ready;
  assign write       = accept || hold_valid;
  assign last_write  = write && (remaining == CNT_WIDTH'(1));
  assign bus.busy    = (state == LOAD);
  assign bus.done    = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = LOAD;
      LOAD:    if (last_write) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt             <= '0;
      remaining          <= '0;
      hold_data          <= '0;
      hold_valid         <= 1'b0;
      bus.weight_wr_data <= '0;
      bus.weight_wr_addr <= '0;
      bus.weight_wr_en   <= 1'b0;
    end else begin
      bus.weight_wr_en <= write;
      if ((state == IDLE) && bus.start) begin
        wr_cnt    <= '0;
        remaining <= CNT_WIDTH'(NUM_WEIGHTS);
      end else if (write) begin
        bus.weight_wr_data <= accept ? bus.i_data[15:0] : hold_data;
        bus.weight_wr_addr <= BASE_ADDR + 32'(wr_cnt);
        wr_cnt             <= wr_cnt + CNT_WIDTH'(1);
        remaining          <= remaining - CNT_WIDTH'(1);
        // The upper half of the final word is dropped on odd weight counts.
        hold_valid         <= accept && (remaining > CNT_WIDTH'(1));
        if (accept) hold_data <= bus.i_data[31:16];
      end
    end
  end

endmodule

// File: tb/tb_pe_weight_loader.sv
// Bench for pe_weight_loader: a cycle table on a 3-weight instance and
// streamed loads on a default-size instance.
module tb_pe_weight_loader;

  localparam int unsigned NW = 226;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pe_weight_loader_if a ();
  pe_weight_loader_if b ();

  pe_weight_loader dut_a (.clk(clk), .rst(rst), .bus(a));
  pe_weight_loader #(.NUM_WEIGHTS(3)) dut_b (.clk(clk), .rst(rst), .bus(b));

  typedef struct {
    logic        start;
    logic        valid;
    logic [31:0] data;
    logic        ready;
    logic        en;
    logic [31:0] addr;
    logic [15:0] wdata;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tv [14];

  function automatic logic [15:0] wgt(input int unsigned i);
    return 16'((i * 37 + 5) ^ 32'h0000_A5C3);
  endfunction

  function automatic logic [31:0] word_of(input int unsigned k);
    return {wgt(2 * k + 1), wgt(2 * k)};
  endfunction

  function automatic logic [63:0] pk(input logic r, input logic e, input logic bz,
                                     input logic d, input logic [15:0] wd,
                                     input logic [31:0] ad);
    return {12'd0, r, e, bz, d, wd, ad};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] obs_a();
    return pk(a.i_ready, a.weight_wr_en, a.busy, a.done, a.weight_wr_data, a.weight_wr_addr);
  endfunction

  // Drives one load on dut_a from cycle 0 (start) and checks every cycle.
  // stop_after != 0 applies rst once that many writes have been seen.
  task automatic load_a(input int unsigned gap_pct, input bit pulse_start,
                        input int unsigned stop_after);
    int unsigned cyc = 0, n_wr = 0, words = 0, done_cyc = 0;
    bit acc = 0, acc1 = 0, acc2 = 0, seen_done = 0;
    bit exp_en, exp_ready, exp_busy, exp_done;
    while (!seen_done && cyc < 3000) begin
      exp_en    = acc1 || acc2;
      exp_ready = (cyc >= 1) && !acc1 && (words < NW / 2);
      exp_done  = exp_en && (n_wr == NW - 1);
      exp_busy  = (cyc >= 1) && !exp_done;
      chk("cycle", {60'd0, a.i_ready, a.weight_wr_en, a.busy, a.done},
                   {60'd0, exp_ready, exp_en, exp_busy, exp_done});
      if (a.weight_wr_en) begin
        chk("write", {16'd0, a.weight_wr_data, a.weight_wr_addr},
                     {16'd0, wgt(n_wr), 32'd23 + n_wr});
        n_wr++;
      end
      if (a.done) begin
        seen_done = 1'b1;
        done_cyc  = cyc;
        chk("done_addr", {32'd0, a.weight_wr_addr}, {32'd0, 32'd248});
      end
      if (stop_after != 0 && n_wr == stop_after) begin
        rst       = 1'b1;
        a.start   = 1'b0;
        a.i_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid", obs_a(), pk(0, 0, 0, 0, 16'h0, 32'h0));
        rst = 1'b0;
        return;
      end
      a.start   = (cyc == 0) || (pulse_start && (cyc == 60 || seen_done));
      a.i_valid = (cyc == 0) ? 1'b1 : ($urandom_range(99) >= gap_pct);
      a.i_data  = word_of(words);
      acc       = a.i_valid && a.i_ready;
      if (acc) words++;
      acc2 = acc1;
      acc1 = acc;
      @(negedge clk);
      cyc++;
    end
    a.start   = 1'b0;
    a.i_valid = 1'b0;
    if (!seen_done) begin
      bad++;
      total++;
      $display("FAIL load_timeout: got no done, required done within 3000 cycles");
    end
    chk("write_count", 64'(n_wr), 64'(NW));
    if (gap_pct == 0) chk("done_cycle", 64'(done_cyc), 64'(NW + 1));
    chk("idle_after", obs_a(), pk(0, 0, 0, 0, wgt(NW - 1), 32'd248));
    @(negedge clk);
    chk("idle_after2", obs_a(), pk(0, 0, 0, 0, wgt(NW - 1), 32'd248));
  endtask

  initial begin
    //          start valid data          ready en addr   wdata     busy done
    tv[0]  = '{1'b0, 1'b1, 32'h1111_2222, 1'b0, 1'b0, 32'd0,  16'h0000, 1'b0, 1'b0};
    tv[1]  = '{1'b0, 1'b1, 32'h1111_2222, 1'b0, 1'b0, 32'd0,  16'h0000, 1'b0, 1'b0};
    tv[2]  = '{1'b1, 1'b1, 32'hBBBB_AAAA, 1'b0, 1'b0, 32'd0,  16'h0000, 1'b0, 1'b0};
    tv[3]  = '{1'b0, 1'b1, 32'hBBBB_AAAA, 1'b1, 1'b0, 32'd0,  16'h0000, 1'b1, 1'b0};
    tv[4]  = '{1'b1, 1'b1, 32'hDDDD_CCCC, 1'b0, 1'b1, 32'd23, 16'hAAAA, 1'b1, 1'b0};
    tv[5]  = '{1'b0, 1'b1, 32'hDDDD_CCCC, 1'b1, 1'b1, 32'd24, 16'hBBBB, 1'b1, 1'b0};
    tv[6]  = '{1'b1, 1'b1, 32'h5555_6666, 1'b0, 1'b1, 32'd25, 16'hCCCC, 1'b0, 1'b1};
    tv[7]  = '{1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'd25, 16'hCCCC, 1'b0, 1'b0};
    tv[8]  = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'd25, 16'hCCCC, 1'b1, 1'b0};
    tv[9]  = '{1'b0, 1'b1, 32'h3333_4444, 1'b1, 1'b0, 32'd25, 16'hCCCC, 1'b1, 1'b0};
    tv[10] = '{1'b0, 1'b1, 32'h9999_8888, 1'b0, 1'b1, 32'd23, 16'h4444, 1'b1, 1'b0};
    tv[11] = '{1'b0, 1'b1, 32'h9999_8888, 1'b1, 1'b1, 32'd24, 16'h3333, 1'b1, 1'b0};
    tv[12] = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 32'd25, 16'h8888, 1'b0, 1'b1};
    tv[13] = '{1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'd25, 16'h8888, 1'b0, 1'b0};

    a.start = 1'b0; a.i_valid = 1'b0; a.i_data = '0;
    b.start = 1'b0; b.i_valid = 1'b0; b.i_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_a", obs_a(), pk(0, 0, 0, 0, 16'h0, 32'h0));
    chk("reset_b", pk(b.i_ready, b.weight_wr_en, b.busy, b.done, b.weight_wr_data,
                      b.weight_wr_addr), pk(0, 0, 0, 0, 16'h0, 32'h0));
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      chk($sformatf("odd_row%0d", i),
          pk(b.i_ready, b.weight_wr_en, b.busy, b.done, b.weight_wr_data, b.weight_wr_addr),
          pk(tv[i].ready, tv[i].en, tv[i].busy, tv[i].done, tv[i].wdata, tv[i].addr));
      b.start   = tv[i].start;
      b.i_valid = tv[i].valid;
      b.i_data  = tv[i].data;
    end
    b.start = 1'b0; b.i_valid = 1'b0;

    // Words offered before start must not be taken.
    a.i_valid = 1'b1;
    a.i_data  = 32'hFEED_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("prestart", obs_a(), pk(0, 0, 0, 0, 16'h0, 32'h0));
    end

    load_a(0, 1'b0, 0);
    load_a(50, 1'b1, 0);
    load_a(0, 1'b0, 10);
    load_a(0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
